// File: rtl/spi_load_scheduler.sv
// Sequences bootloader and page loads toward an SPI image loader: selects access type,
// counts loader write strobes, enforces inter-load gaps and a per-load timeout.
module spi_load_scheduler #(
  parameter logic [15:0] BOOT_BITS   = 16'd4096,
  parameter logic [15:0] PAGE_BITS   = 16'd1024,
  parameter int unsigned PREP_CYCLES = 8,
  parameter int unsigned GAP_CYCLES  = 4,
  parameter logic [19:0] TIMEOUT     = 20'd200000
) (
  input  logic        MCLK,
  input  logic        RST,
  input  logic [2:0]  IMGSEL,
  input  logic        BOOTREQ,
  input  logic        PAGEREQ,
  input  logic [11:0] PAGEPOS,
  input  logic        nOUTBUFWCLKEN,
  output logic [2:0]  IMGNUM,
  output logic [2:0]  ACCTYPE,
  output logic [11:0] ABSPOS,
  output logic        BUSY,
  output logic        DONE,
  output logic        BOOTDONE,
  output logic        ERR,
  output logic        OVERRUN
);

  localparam logic [11:0] MAX_POS   = 12'd2052;
  localparam logic [2:0]  ACC_IDLE  = 3'b000;
  localparam logic [2:0]  ACC_PREP  = 3'b001;
  localparam logic [2:0]  ACC_BOOT  = 3'b110;
  localparam logic [2:0]  ACC_PAGE  = 3'b111;
  localparam logic [15:0] PREP_LAST = 16'(PREP_CYCLES - 1);
  localparam logic [15:0] GAP_LAST  = 16'(GAP_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE,
    BOOT_RUN,
    GAP,
    PAGE_PREP,
    PAGE_RUN,
    FAULT
  } state_t;

  state_t      state;
  logic [15:0] bit_cnt;
  logic [19:0] tmo_cnt;
  logic [15:0] phase_cnt;
  logic        pend_valid;
  logic [2:0]  pend_img;
  logic [11:0] pend_pos;

  logic        pos_bad;
  logic        run_state;
  logic        req_busy;
  logic [15:0] run_limit;
  logic        bit_hit;
  logic        tmo_hit;

  // Request qualification and end-of-load detection for the current cycle
  always_comb begin
    pos_bad   = PAGEPOS > MAX_POS;
    run_state = (state == BOOT_RUN) || (state == PAGE_RUN);
    req_busy  = (state == BOOT_RUN) || (state == GAP) ||
                (state == PAGE_PREP) || (state == PAGE_RUN);
    run_limit = (state == BOOT_RUN) ? BOOT_BITS : PAGE_BITS;
    bit_hit   = run_state && !nOUTBUFWCLKEN && (bit_cnt == run_limit - 16'd1);
    tmo_hit   = tmo_cnt == TIMEOUT - 20'd1;
  end

  always_ff @(posedge MCLK) begin
    if (RST) begin
      state      <= IDLE;
      ACCTYPE    <= ACC_IDLE;
      IMGNUM     <= 3'd0;
      ABSPOS     <= 12'd0;
      BUSY       <= 1'b0;
      DONE       <= 1'b0;
      BOOTDONE   <= 1'b0;
      ERR        <= 1'b0;
      OVERRUN    <= 1'b0;
      bit_cnt    <= 16'd0;
      tmo_cnt    <= 20'd0;
      phase_cnt  <= 16'd0;
      pend_valid <= 1'b0;
      pend_img   <= 3'd0;
      pend_pos   <= 12'd0;
    end else begin
      DONE    <= 1'b0;
      OVERRUN <= 1'b0;

      // Page requests arriving mid-sequence go to the one-deep pending slot
      if (req_busy && PAGEREQ) begin
        if (pos_bad) begin
          ERR <= 1'b1;
        end else if (pend_valid) begin
          OVERRUN <= 1'b1;
        end else begin
          pend_valid <= 1'b1;
          pend_img   <= IMGSEL;
          pend_pos   <= PAGEPOS;
        end
      end

      case (state)
        IDLE: begin
          if (BOOTREQ) begin
            state   <= BOOT_RUN;
            ACCTYPE <= ACC_BOOT;
            IMGNUM  <= IMGSEL;
            ABSPOS  <= 12'd0;
            BUSY    <= 1'b1;
            bit_cnt <= 16'd0;
            tmo_cnt <= 20'd0;
            if (PAGEREQ) begin
              if (pos_bad) begin
                ERR <= 1'b1;
              end else begin
                pend_valid <= 1'b1;
                pend_img   <= IMGSEL;
                pend_pos   <= PAGEPOS;
              end
            end
          end else if (PAGEREQ) begin
            if (pos_bad || !BOOTDONE) begin
              ERR <= 1'b1;
            end else begin
              state     <= PAGE_PREP;
              ACCTYPE   <= ACC_PREP;
              IMGNUM    <= IMGSEL;
              ABSPOS    <= PAGEPOS;
              BUSY      <= 1'b1;
              phase_cnt <= 16'd0;
            end
          end
        end

        BOOT_RUN, PAGE_RUN: begin
          if (!nOUTBUFWCLKEN) begin
            bit_cnt <= bit_cnt + 16'd1;
          end
          if (bit_hit) begin
            state     <= GAP;
            ACCTYPE   <= ACC_IDLE;
            DONE      <= 1'b1;
            phase_cnt <= 16'd0;
            if (state == BOOT_RUN) begin
              BOOTDONE <= 1'b1;
            end
          end else if (tmo_hit) begin
            state      <= FAULT;
            ACCTYPE    <= ACC_IDLE;
            BUSY       <= 1'b0;
            ERR        <= 1'b1;
            pend_valid <= 1'b0;
          end else begin
            tmo_cnt <= tmo_cnt + 20'd1;
          end
        end

        GAP: begin
          if (phase_cnt == GAP_LAST) begin
            phase_cnt <= 16'd0;
            if (pend_valid) begin
              state      <= PAGE_PREP;
              ACCTYPE    <= ACC_PREP;
              IMGNUM     <= pend_img;
              ABSPOS     <= pend_pos;
              pend_valid <= 1'b0;
            end else if (PAGEREQ && !pos_bad) begin
              // A request landing on the last gap cycle launches directly
              state      <= PAGE_PREP;
              ACCTYPE    <= ACC_PREP;
              IMGNUM     <= IMGSEL;
              ABSPOS     <= PAGEPOS;
              pend_valid <= 1'b0;
            end else begin
              state   <= IDLE;
              BUSY    <= 1'b0;
            end
          end else begin
            phase_cnt <= phase_cnt + 16'd1;
          end
        end

        PAGE_PREP: begin
          if (phase_cnt == PREP_LAST) begin
            state   <= PAGE_RUN;
            ACCTYPE <= ACC_PAGE;
            bit_cnt <= 16'd0;
            tmo_cnt <= 20'd0;
          end else begin
            phase_cnt <= phase_cnt + 16'd1;
          end
        end

        FAULT: begin
          state <= FAULT;
        end

        default: begin
          state   <= IDLE;
          ACCTYPE <= ACC_IDLE;
          BUSY    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_spi_load_scheduler.sv
// Scoreboard bench for spi_load_scheduler: expected load starts and completions are
// queued as requests are driven and checked when the DUT starts or finishes a load.
module tb_spi_load_scheduler;

  localparam logic [15:0] BOOT_BITS   = 16'd4096;
  localparam logic [15:0] PAGE_BITS   = 16'd1024;
  localparam int          PREP_CYCLES = 8;
  localparam int          GAP_CYCLES  = 4;
  localparam int          TMO         = 5000;

  logic        MCLK = 1'b0;
  logic        RST = 1'b1;
  logic [2:0]  IMGSEL = 3'd0;
  logic        BOOTREQ = 1'b0;
  logic        PAGEREQ = 1'b0;
  logic [11:0] PAGEPOS = 12'd0;
  logic        nOUTBUFWCLKEN = 1'b1;
  logic [2:0]  IMGNUM;
  logic [2:0]  ACCTYPE;
  logic [11:0] ABSPOS;
  logic        BUSY;
  logic        DONE;
  logic        BOOTDONE;
  logic        ERR;
  logic        OVERRUN;

  typedef struct {
    logic [2:0]  acc;
    logic [2:0]  img;
    logic [11:0] pos;
  } start_t;

  start_t start_q[$];
  int     done_q[$];
  int     pass_cnt = 0;
  int     check_cnt = 0;
  int     cyc = 0;
  int     strobe_cnt = 0;
  int     last_strobe_cyc = 0;
  int     ovr_seen = 0;
  int     ovr_exp = 0;
  bit     strobe_en = 1'b1;
  bit     strobe_rand = 1'b0;
  logic [2:0] prev_acc = 3'd0;
  logic   run_now;
  logic   run_prev;
  start_t exp_s;
  int     exp_bits;

  spi_load_scheduler #(
    .BOOT_BITS  (BOOT_BITS),
    .PAGE_BITS  (PAGE_BITS),
    .PREP_CYCLES(PREP_CYCLES),
    .GAP_CYCLES (GAP_CYCLES),
    .TIMEOUT    (20'(TMO))
  ) dut (
    .MCLK         (MCLK),
    .RST          (RST),
    .IMGSEL       (IMGSEL),
    .BOOTREQ      (BOOTREQ),
    .PAGEREQ      (PAGEREQ),
    .PAGEPOS      (PAGEPOS),
    .nOUTBUFWCLKEN(nOUTBUFWCLKEN),
    .IMGNUM       (IMGNUM),
    .ACCTYPE      (ACCTYPE),
    .ABSPOS       (ABSPOS),
    .BUSY         (BUSY),
    .DONE         (DONE),
    .BOOTDONE     (BOOTDONE),
    .ERR          (ERR),
    .OVERRUN      (OVERRUN)
  );

  always #5 MCLK = ~MCLK;

  // Monitor pops the scoreboard, then the loader model drives the next strobe
  always @(negedge MCLK) begin
    cyc++;
    run_now  = (ACCTYPE === 3'b110) || (ACCTYPE === 3'b111);
    run_prev = (prev_acc === 3'b110) || (prev_acc === 3'b111);
    if (!RST) begin
      if (run_now && !run_prev) begin
        check_cnt++;
        if (start_q.size() == 0) begin
          $display("FAIL load_start: unexpected start acctype=%b imgnum=%0d abspos=%0d",
                   ACCTYPE, IMGNUM, ABSPOS);
        end else begin
          exp_s = start_q.pop_front();
          if (ACCTYPE !== exp_s.acc || IMGNUM !== exp_s.img || ABSPOS !== exp_s.pos)
            $display("FAIL load_start: got acctype=%b imgnum=%0d abspos=%0d, want acctype=%b imgnum=%0d abspos=%0d",
                     ACCTYPE, IMGNUM, ABSPOS, exp_s.acc, exp_s.img, exp_s.pos);
          else
            pass_cnt++;
        end
        strobe_cnt = 0;
      end
      if (DONE === 1'b1) begin
        check_cnt++;
        if (done_q.size() == 0) begin
          $display("FAIL load_done: unexpected DONE pulse at cycle %0d", cyc);
        end else begin
          exp_bits = done_q.pop_front();
          if (strobe_cnt != exp_bits || (cyc - last_strobe_cyc) != 1 || ACCTYPE !== 3'b000)
            $display("FAIL load_done: got strobes=%0d lag=%0d acctype=%b, want strobes=%0d lag=1 acctype=000",
                     strobe_cnt, cyc - last_strobe_cyc, ACCTYPE, exp_bits);
          else
            pass_cnt++;
        end
      end
      if (OVERRUN === 1'b1) ovr_seen++;
    end
    prev_acc = ACCTYPE;
    if (!RST && strobe_en && run_now && (!strobe_rand || $urandom_range(3) != 0)) begin
      nOUTBUFWCLKEN = 1'b0;
      strobe_cnt++;
      last_strobe_cyc = cyc;
    end else begin
      nOUTBUFWCLKEN = 1'b1;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic do_reset();
    @(negedge MCLK);
    RST = 1'b1;
    BOOTREQ = 1'b0;
    PAGEREQ = 1'b0;
    repeat (2) @(negedge MCLK);
    RST = 1'b0;
    start_q.delete();
    done_q.delete();
  endtask

  task automatic send_req(input logic boot, input logic page, input logic [2:0] img,
                          input logic [11:0] pos);
    @(negedge MCLK);
    BOOTREQ = boot;
    PAGEREQ = page;
    IMGSEL  = img;
    PAGEPOS = pos;
    @(negedge MCLK);
    BOOTREQ = 1'b0;
    PAGEREQ = 1'b0;
  endtask

  task automatic wait_for_done(input int budget, input string tag);
    int n = 0;
    while (DONE !== 1'b1 && n < budget) begin
      @(negedge MCLK);
      n++;
    end
    if (DONE !== 1'b1) begin
      check_cnt++;
      $display("FAIL %s: DONE not seen within %0d cycles", tag, budget);
    end
  endtask

  task automatic wait_acc(input logic [2:0] val, input int budget, input string tag);
    int n = 0;
    while (ACCTYPE !== val && n < budget) begin
      @(negedge MCLK);
      n++;
    end
    if (ACCTYPE !== val) begin
      check_cnt++;
      $display("FAIL %s: acctype=%b, want %b within %0d cycles", tag, ACCTYPE, val, budget);
    end
  endtask

  task automatic test_reset(input string tag);
    do_reset();
    check_cnt++;
    if (ACCTYPE !== 3'b000) $display("FAIL %s_acctype: got %b want 000", tag, ACCTYPE);
    else pass_cnt++;
    check_cnt++;
    if (IMGNUM !== 3'd0 || ABSPOS !== 12'd0)
      $display("FAIL %s_img_pos: got imgnum=%0d abspos=%0d want 0/0", tag, IMGNUM, ABSPOS);
    else pass_cnt++;
    check_cnt++;
    if ({BUSY, DONE, BOOTDONE, ERR, OVERRUN} !== 5'b00000)
      $display("FAIL %s_flags: got busy,done,bootdone,err,overrun=%b want 00000", tag,
               {BUSY, DONE, BOOTDONE, ERR, OVERRUN});
    else pass_cnt++;
  endtask

  task automatic test_page_before_boot();
    send_req(1'b0, 1'b1, 3'd1, 12'd10);
    repeat (3) @(negedge MCLK);
    check_cnt++;
    if (ERR !== 1'b1 || ACCTYPE !== 3'b000 || BUSY !== 1'b0)
      $display("FAIL page_before_boot: got err=%b acctype=%b busy=%b want 1/000/0", ERR, ACCTYPE, BUSY);
    else pass_cnt++;
  endtask

  task automatic test_boot(input logic [2:0] img);
    int n = 0;
    strobe_rand = 1'b0;
    start_q.push_back('{3'b110, img, 12'd0});
    done_q.push_back(int'(BOOT_BITS));
    send_req(1'b1, 1'b0, img, 12'd0);
    check_cnt++;
    if (ACCTYPE !== 3'b110 || BUSY !== 1'b1)
      $display("FAIL boot_accept: got acctype=%b busy=%b want 110/1", ACCTYPE, BUSY);
    else pass_cnt++;
    wait_for_done(5000, "boot_done");
    check_cnt++;
    if (BOOTDONE !== 1'b1) $display("FAIL boot_bootdone: got %b want 1", BOOTDONE);
    else pass_cnt++;
    while (BUSY === 1'b1 && ACCTYPE === 3'b000 && n < 20) begin
      n++;
      @(negedge MCLK);
    end
    check_cnt++;
    if (n != GAP_CYCLES || BUSY !== 1'b0 || ACCTYPE !== 3'b000)
      $display("FAIL boot_gap: got gap=%0d busy=%b acctype=%b want gap=%0d busy=0 acctype=000",
               n, BUSY, ACCTYPE, GAP_CYCLES);
    else pass_cnt++;
  endtask

  task automatic test_page(input logic [2:0] img, input logic [11:0] pos);
    int n = 0;
    strobe_rand = 1'b1;
    start_q.push_back('{3'b111, img, pos});
    done_q.push_back(int'(PAGE_BITS));
    send_req(1'b0, 1'b1, img, pos);
    while (ACCTYPE === 3'b001 && n < 50) begin
      n++;
      @(negedge MCLK);
    end
    check_cnt++;
    if (n != PREP_CYCLES || ACCTYPE !== 3'b111 || ABSPOS !== pos)
      $display("FAIL page_prep: got prep=%0d acctype=%b abspos=%0d want prep=%0d acctype=111 abspos=%0d",
               n, ACCTYPE, ABSPOS, PREP_CYCLES, pos);
    else pass_cnt++;
    wait_for_done(4000, "page_done");
    repeat (GAP_CYCLES + 1) @(negedge MCLK);
    check_cnt++;
    if (BUSY !== 1'b0 || ERR !== 1'b0)
      $display("FAIL page_idle: got busy=%b err=%b want 0/0", BUSY, ERR);
    else pass_cnt++;
  endtask

  task automatic test_overrun();
    int n = 0;
    strobe_rand = 1'b1;
    start_q.push_back('{3'b111, 3'd1, 12'd100});
    done_q.push_back(int'(PAGE_BITS));
    send_req(1'b0, 1'b1, 3'd1, 12'd100);
    wait_acc(3'b111, 50, "overrun_first_run");
    repeat (10) @(negedge MCLK);
    start_q.push_back('{3'b111, 3'd3, 12'd5});
    done_q.push_back(int'(PAGE_BITS));
    send_req(1'b0, 1'b1, 3'd3, 12'd5);
    check_cnt++;
    if (OVERRUN !== 1'b0) $display("FAIL overrun_first_req: got %b want 0", OVERRUN);
    else pass_cnt++;
    repeat (3) @(negedge MCLK);
    ovr_exp++;
    send_req(1'b0, 1'b1, 3'd4, 12'd9);
    check_cnt++;
    if (OVERRUN !== 1'b1) $display("FAIL overrun_pulse: got %b want 1", OVERRUN);
    else pass_cnt++;
    @(negedge MCLK);
    check_cnt++;
    if (OVERRUN !== 1'b0) $display("FAIL overrun_width: got %b want 0", OVERRUN);
    else pass_cnt++;
    wait_for_done(4000, "overrun_first_done");
    while (ACCTYPE === 3'b000 && BUSY === 1'b1 && n < 20) begin
      n++;
      @(negedge MCLK);
    end
    check_cnt++;
    if (n != GAP_CYCLES || ACCTYPE !== 3'b001 || BUSY !== 1'b1 || ABSPOS !== 12'd5)
      $display("FAIL overrun_chain: got gap=%0d acctype=%b busy=%b abspos=%0d want gap=%0d acctype=001 busy=1 abspos=5",
               n, ACCTYPE, BUSY, ABSPOS, GAP_CYCLES);
    else pass_cnt++;
    @(negedge MCLK);
    wait_for_done(4000, "overrun_second_done");
    repeat (GAP_CYCLES + 1) @(negedge MCLK);
  endtask

  task automatic test_same_cycle();
    int n = 0;
    strobe_rand = 1'b0;
    start_q.push_back('{3'b110, 3'd6, 12'd0});
    done_q.push_back(int'(BOOT_BITS));
    start_q.push_back('{3'b111, 3'd6, 12'd2052});
    done_q.push_back(int'(PAGE_BITS));
    send_req(1'b1, 1'b1, 3'd6, 12'd2052);
    check_cnt++;
    if (ACCTYPE !== 3'b110 || ERR !== 1'b0)
      $display("FAIL same_cycle_boot_first: got acctype=%b err=%b want 110/0", ACCTYPE, ERR);
    else pass_cnt++;
    repeat (20) @(negedge MCLK);
    send_req(1'b1, 1'b0, 3'd1, 12'd0);
    check_cnt++;
    if (ACCTYPE !== 3'b110 || IMGNUM !== 3'd6)
      $display("FAIL boot_ignored_busy: got acctype=%b imgnum=%0d want 110/6", ACCTYPE, IMGNUM);
    else pass_cnt++;
    wait_for_done(5000, "same_cycle_boot_done");
    while (ACCTYPE === 3'b000 && n < 20) begin
      n++;
      @(negedge MCLK);
    end
    check_cnt++;
    if (n != GAP_CYCLES || ACCTYPE !== 3'b001 || BUSY !== 1'b1)
      $display("FAIL same_cycle_page_follows: got gap=%0d acctype=%b busy=%b want gap=%0d acctype=001 busy=1",
               n, ACCTYPE, BUSY, GAP_CYCLES);
    else pass_cnt++;
    @(negedge MCLK);
    wait_for_done(4000, "same_cycle_page_done");
    repeat (GAP_CYCLES + 1) @(negedge MCLK);
    check_cnt++;
    if (ERR !== 1'b0 || BUSY !== 1'b0)
      $display("FAIL pos_2052_legal: got err=%b busy=%b want 0/0", ERR, BUSY);
    else pass_cnt++;
  endtask

  task automatic test_timeout();
    strobe_en = 1'b0;
    start_q.push_back('{3'b111, 3'd0, 12'd7});
    send_req(1'b0, 1'b1, 3'd0, 12'd7);
    wait_acc(3'b111, 50, "timeout_run");
    repeat (TMO - 5) @(negedge MCLK);
    check_cnt++;
    if (ACCTYPE !== 3'b111 || BUSY !== 1'b1 || ERR !== 1'b0)
      $display("FAIL timeout_early: got acctype=%b busy=%b err=%b want 111/1/0", ACCTYPE, BUSY, ERR);
    else pass_cnt++;
    repeat (10) @(negedge MCLK);
    check_cnt++;
    if (ACCTYPE !== 3'b000 || BUSY !== 1'b0 || ERR !== 1'b1)
      $display("FAIL timeout_fault: got acctype=%b busy=%b err=%b want 000/0/1", ACCTYPE, BUSY, ERR);
    else pass_cnt++;
    strobe_en = 1'b1;
    send_req(1'b1, 1'b1, 3'd2, 12'd20);
    repeat (5) @(negedge MCLK);
    check_cnt++;
    if (ACCTYPE !== 3'b000 || BUSY !== 1'b0)
      $display("FAIL fault_ignores_req: got acctype=%b busy=%b want 000/0", ACCTYPE, BUSY);
    else pass_cnt++;
  endtask

  task automatic test_reset_mid_load();
    strobe_rand = 1'b0;
    start_q.push_back('{3'b110, 3'd5, 12'd0});
    send_req(1'b1, 1'b0, 3'd5, 12'd0);
    repeat (50) @(negedge MCLK);
    check_cnt++;
    if (ACCTYPE !== 3'b110 || BUSY !== 1'b1)
      $display("FAIL mid_load_running: got acctype=%b busy=%b want 110/1", ACCTYPE, BUSY);
    else pass_cnt++;
    test_reset("reset_mid_load");
  endtask

  task automatic test_bad_pos();
    send_req(1'b0, 1'b1, 3'd1, 12'd2053);
    repeat (4) @(negedge MCLK);
    check_cnt++;
    if (ERR !== 1'b1 || ACCTYPE !== 3'b000 || BUSY !== 1'b0)
      $display("FAIL bad_pos: got err=%b acctype=%b busy=%b want 1/000/0", ERR, ACCTYPE, BUSY);
    else pass_cnt++;
  endtask

  initial begin
    test_reset("reset_initial");
    test_page_before_boot();
    test_reset("reset_after_err");
    test_boot(3'd2);
    test_page(3'd5, 12'd1018);
    test_overrun();
    test_same_cycle();
    test_timeout();
    test_reset("reset_after_fault");
    test_reset_mid_load();
    test_boot(3'd2);
    test_bad_pos();
    repeat (5) @(negedge MCLK);
    check_cnt++;
    if (start_q.size() != 0 || done_q.size() != 0)
      $display("FAIL scoreboard_drained: got starts=%0d dones=%0d pending, want 0/0",
               start_q.size(), done_q.size());
    else pass_cnt++;
    check_cnt++;
    if (ovr_seen != ovr_exp)
      $display("FAIL overrun_count: got %0d want %0d", ovr_seen, ovr_exp);
    else pass_cnt++;
    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

endmodule
